// File: rtl/model_read_weighting_multimode.sv
// -----------------------------------------------------------------------------
// model_read_weighting_multimode
//   Streams the read weighting w(t;i,j) = sum_m pi(t;i)[m] * x_m(t;i,j) for
//   R read heads and N memory locations, head-major (i outer, j inner).
//   One mode-vector (PI) beat is taken before each head, then N weighting (X)
//   beats. Results leave through a single-entry output register with a
//   valid/ready handshake; latency from an X transfer to W_OUT is one cycle.
//
// Ports
//   CLK, RST          clock; asynchronous active-high reset
//   START             start pulse, sampled in IDLE only
//   READY             one-cycle done pulse
//   BUSY              high whenever not IDLE
//   SIZE_R_IN/N_IN    head / location counts, latched at START
//   PI_VALID/READY/IN mode-coefficient beat, slot m = [m*DATA_SIZE +: DATA_SIZE]
//   X_VALID/READY/IN  per-mode weighting beat, slot 0=b, 1=c, 2=f, ...
//   W_OUT_*           output beat: value, head index, location index, last flag
// -----------------------------------------------------------------------------
module model_read_weighting_multimode #(
   parameter int DATA_SIZE    = 32,
   parameter int FRAC_SIZE    = 16,
   parameter int CONTROL_SIZE = 16,
   parameter int MODES        = 3
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         START,
   output logic                         READY,
   output logic                         BUSY,
   input  logic [CONTROL_SIZE-1:0]      SIZE_R_IN,
   input  logic [CONTROL_SIZE-1:0]      SIZE_N_IN,
   input  logic                         PI_VALID,
   output logic                         PI_READY,
   input  logic [MODES*DATA_SIZE-1:0]   PI_IN,
   input  logic                         X_VALID,
   output logic                         X_READY,
   input  logic [MODES*DATA_SIZE-1:0]   X_IN,
   output logic                         W_OUT_VALID,
   input  logic                         W_OUT_READY,
   output logic [DATA_SIZE-1:0]         W_OUT,
   output logic [CONTROL_SIZE-1:0]      W_OUT_I,
   output logic [CONTROL_SIZE-1:0]      W_OUT_J,
   output logic                         W_OUT_LAST
);

   localparam int DW    = DATA_SIZE;
   localparam int CW    = CONTROL_SIZE;
   localparam int ACC_W = DATA_SIZE + $clog2(MODES) + 1;
   // Only the low FRAC_SIZE+ACC_W product bits survive the shift and the
   // accumulator truncation, so the multiply is built at that width.
   localparam int PW    = FRAC_SIZE + ACC_W;

   localparam logic [CW-1:0]           ONE    = {{(CW-1){1'b0}}, 1'b1};
   localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, LOAD_PI, STREAM, DRAIN, DONE} state_t;

   state_t                       state_q, state_d;
   logic [CW-1:0]                r_q, r_d, n_q, n_d, i_q, i_d, j_q, j_d;
   logic [MODES-1:0][DW-1:0]     pi_q, pi_d;
   logic                         wv_q, wv_d, wl_q, wl_d;
   logic [DW-1:0]                w_q, w_d;
   logic [CW-1:0]                wi_q, wi_d, wj_q, wj_d;

   logic                         pi_rdy, x_rdy, i_last, j_last;
   logic [DW-1:0]                sat;

   // ---------------------------------------------------------------- datapath
   logic [PW-1:0]                a_ext, b_ext;
   logic signed [PW-1:0]         prod;
   logic signed [ACC_W-1:0]      acc;
   logic [FRAC_SIZE-1:0]         unused_frac;

   always_comb begin
      acc         = '0;
      unused_frac = '0;
      a_ext       = '0;
      b_ext       = '0;
      prod        = '0;
      for (int m = 0; m < MODES; m++) begin
         a_ext = {{(PW-DW){pi_q[m][DW-1]}}, pi_q[m]};
         b_ext = {{(PW-DW){X_IN[m*DW+DW-1]}}, X_IN[m*DW +: DW]};
         prod  = a_ext * b_ext;
         // Dropping the low bits of a two's complement value floors it.
         acc         = acc + prod[PW-1:FRAC_SIZE];
         unused_frac = unused_frac ^ prod[FRAC_SIZE-1:0];
      end
      if (acc > SAT_HI)      sat = {1'b0, {(DW-1){1'b1}}};
      else if (acc < SAT_LO) sat = {1'b1, {(DW-1){1'b0}}};
      else                   sat = acc[DW-1:0];
   end

   // ------------------------------------------------------------ control FSM
   assign i_last = (i_q == r_q - ONE);
   assign j_last = (j_q == n_q - ONE);

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      n_d     = n_q;
      i_d     = i_q;
      j_d     = j_q;
      pi_d    = pi_q;
      wv_d    = wv_q;
      w_d     = w_q;
      wi_d    = wi_q;
      wj_d    = wj_q;
      wl_d    = wl_q;
      pi_rdy  = (state_q == LOAD_PI);
      // Accept a new beat whenever the output slot is empty or being emptied.
      x_rdy   = (state_q == STREAM) && (!wv_q || W_OUT_READY);

      if (wv_q && W_OUT_READY) wv_d = 1'b0;

      case (state_q)
         IDLE: if (START) begin
            r_d = SIZE_R_IN;
            n_d = SIZE_N_IN;
            i_d = '0;
            j_d = '0;
            state_d = (SIZE_R_IN == '0 || SIZE_N_IN == '0) ? DONE : LOAD_PI;
         end
         LOAD_PI: if (PI_VALID) begin
            pi_d    = PI_IN;
            state_d = STREAM;
         end
         STREAM: if (X_VALID && x_rdy) begin
            wv_d = 1'b1;
            w_d  = sat;
            wi_d = i_q;
            wj_d = j_q;
            wl_d = i_last && j_last;
            if (!j_last) begin
               j_d = j_q + ONE;
            end else if (!i_last) begin
               j_d     = '0;
               i_d     = i_q + ONE;
               state_d = LOAD_PI;
            end else begin
               state_d = DRAIN;
            end
         end
         DRAIN:   if (!wv_q || W_OUT_READY) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         r_q     <= '0;
         n_q     <= '0;
         i_q     <= '0;
         j_q     <= '0;
         pi_q    <= '0;
         wv_q    <= 1'b0;
         w_q     <= '0;
         wi_q    <= '0;
         wj_q    <= '0;
         wl_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         n_q     <= n_d;
         i_q     <= i_d;
         j_q     <= j_d;
         pi_q    <= pi_d;
         wv_q    <= wv_d;
         w_q     <= w_d;
         wi_q    <= wi_d;
         wj_q    <= wj_d;
         wl_q    <= wl_d;
      end
   end

   assign READY       = (state_q == DONE);
   assign BUSY        = (state_q != IDLE);
   assign PI_READY    = pi_rdy;
   assign X_READY     = x_rdy;
   assign W_OUT_VALID = wv_q;
   assign W_OUT       = w_q;
   assign W_OUT_I     = wi_q;
   assign W_OUT_J     = wj_q;
   assign W_OUT_LAST  = wl_q;

endmodule

// File: tb/tb_model_read_weighting_multimode.sv
// Directed bench for model_read_weighting_multimode (DATA_SIZE=32, FRAC=16,
// MODES=3). Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_model_read_weighting_multimode;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        START = 1'b0;
   logic        READY, BUSY;
   logic [15:0] SIZE_R_IN = '0, SIZE_N_IN = '0;
   logic        PI_VALID = 1'b0, PI_READY;
   logic [95:0] PI_IN = '0;
   logic        X_VALID = 1'b0, X_READY;
   logic [95:0] X_IN = '0;
   logic        W_OUT_VALID, W_OUT_READY = 1'b0;
   logic [31:0] W_OUT;
   logic [15:0] W_OUT_I, W_OUT_J;
   logic        W_OUT_LAST;

   model_read_weighting_multimode dut (
      .CLK(CLK), .RST(RST), .START(START), .READY(READY), .BUSY(BUSY),
      .SIZE_R_IN(SIZE_R_IN), .SIZE_N_IN(SIZE_N_IN),
      .PI_VALID(PI_VALID), .PI_READY(PI_READY), .PI_IN(PI_IN),
      .X_VALID(X_VALID), .X_READY(X_READY), .X_IN(X_IN),
      .W_OUT_VALID(W_OUT_VALID), .W_OUT_READY(W_OUT_READY), .W_OUT(W_OUT),
      .W_OUT_I(W_OUT_I), .W_OUT_J(W_OUT_J), .W_OUT_LAST(W_OUT_LAST)
   );

   always #5 CLK = ~CLK;

   int nvec = 0;
   int nerr = 0;

   logic [95:0] pi_tab [4];
   logic [95:0] x_tab  [16];
   logic [31:0] ow [16];
   logic [15:0] oi [16];
   logic [15:0] oj [16];
   logic        ol [16];
   int          ocyc [16];
   int          xcyc [16];
   int          nout, nx, npi, rdy_cnt, rdy_cyc;
   bit          both_seen, pi_seen, x_seen, stall_bad, timed_out;

   function automatic logic [95:0] pk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      return {c, b, a};
   endfunction

   // Runs one job with always-valid PI/X sources; records every accepted
   // output beat and handshake events for the calling test to judge.
   task automatic run_job(input int r, input int n, input int stall_at, input int stall_len, input int restart_at);
      int pi_idx, x_idx, tail;
      logic [31:0] hw;
      logic [15:0] hi, hj;
      nout = 0; nx = 0; rdy_cnt = 0; rdy_cyc = -1;
      both_seen = 0; pi_seen = 0; x_seen = 0; stall_bad = 0; timed_out = 0;
      pi_idx = 0; x_idx = 0; tail = -1; hw = '0; hi = '0; hj = '0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         @(negedge CLK);
         START       = (cyc == 0) || (cyc == restart_at);
         SIZE_R_IN   = (cyc == restart_at) ? 16'd7 : 16'(r);
         SIZE_N_IN   = (cyc == restart_at) ? 16'd5 : 16'(n);
         PI_VALID    = 1'b1;
         PI_IN       = pi_tab[pi_idx % 4];
         X_VALID     = 1'b1;
         X_IN        = x_tab[x_idx % 16];
         W_OUT_READY = !(cyc >= stall_at && cyc < stall_at + stall_len);
         #1;
         if (PI_READY && X_READY) both_seen = 1;
         if (PI_READY) pi_seen = 1;
         if (X_READY) x_seen = 1;
         if (!W_OUT_READY) begin
            if (cyc == stall_at) begin hw = W_OUT; hi = W_OUT_I; hj = W_OUT_J; end
            if (X_READY || !W_OUT_VALID || W_OUT !== hw || W_OUT_I !== hi || W_OUT_J !== hj)
               stall_bad = 1;
         end
         if (PI_VALID && PI_READY) pi_idx++;
         if (X_VALID && X_READY) begin
            if (nx < 16) xcyc[nx] = cyc;
            nx++; x_idx++;
         end
         if (W_OUT_VALID && W_OUT_READY) begin
            if (nout < 16) begin
               ow[nout] = W_OUT; oi[nout] = W_OUT_I; oj[nout] = W_OUT_J;
               ol[nout] = W_OUT_LAST; ocyc[nout] = cyc;
            end
            nout++;
         end
         if (READY) begin
            rdy_cnt++;
            if (rdy_cyc < 0) begin rdy_cyc = cyc; tail = cyc + 3; end
         end
         if (cyc == tail) break;
      end
      if (tail < 0) timed_out = 1;
      npi = pi_idx;
      START = 1'b0; PI_VALID = 1'b0; X_VALID = 1'b0; W_OUT_READY = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      nvec++; if ({READY, BUSY, PI_READY, X_READY, W_OUT_VALID, W_OUT_LAST} !== 6'b0) begin
         nerr++; $display("FAIL reset_ctrl: got %b, expected 000000", {READY, BUSY, PI_READY, X_READY, W_OUT_VALID, W_OUT_LAST});
      end
      nvec++; if ({W_OUT, W_OUT_I, W_OUT_J} !== 64'h0) begin
         nerr++; $display("FAIL reset_data: got %h, expected 0", {W_OUT, W_OUT_I, W_OUT_J});
      end
      @(negedge CLK); RST = 1'b0;
      repeat (2) @(negedge CLK);
      #1;
      nvec++; if (BUSY !== 1'b0 || READY !== 1'b0) begin
         nerr++; $display("FAIL reset_idle: got busy=%b ready=%b, expected 0 0", BUSY, READY);
      end
   endtask

   // 0.5*1 + 0.25*2 + 0.25*4 = 2.0
   task automatic test_single();
      pi_tab[0] = pk(32'h8000, 32'h4000, 32'h4000);
      x_tab[0]  = pk(32'h10000, 32'h20000, 32'h40000);
      run_job(1, 1, -100, 0, -1);
      nvec++; if (timed_out || nout !== 1) begin
         nerr++; $display("FAIL single_count: got %0d beats timeout=%0d, expected 1", nout, timed_out);
      end
      nvec++; if (ow[0] !== 32'h00020000 || oi[0] !== 16'd0 || oj[0] !== 16'd0 || ol[0] !== 1'b1) begin
         nerr++; $display("FAIL single_beat: got w=%h i=%0d j=%0d last=%b, expected 00020000 0 0 1", ow[0], oi[0], oj[0], ol[0]);
      end
      nvec++; if (ocyc[0] !== xcyc[0] + 1) begin
         nerr++; $display("FAIL single_latency: got out cyc %0d, expected %0d", ocyc[0], xcyc[0] + 1);
      end
      nvec++; if (rdy_cnt !== 1 || rdy_cyc !== ocyc[0] + 1) begin
         nerr++; $display("FAIL single_ready: got %0d pulses at cyc %0d, expected 1 at %0d", rdy_cnt, rdy_cyc, ocyc[0] + 1);
      end
   endtask

   // Head 0 selects b (pi=1.0), head 1 selects c scaled by 2.0.
   task automatic load_multi_tables();
      pi_tab[0] = pk(32'h10000, 32'h0, 32'h0);
      pi_tab[1] = pk(32'h0, 32'h20000, 32'h0);
      for (int k = 0; k < 6; k++)
         x_tab[k] = pk(32'(k * 32'h10000 + 32'h100), 32'((k + 1) * 32'h1000), 32'h7);
   endtask

   task automatic test_multi_head();
      logic [31:0] e;
      load_multi_tables();
      run_job(2, 3, -100, 0, -1);
      nvec++; if (timed_out || nout !== 6 || npi !== 2) begin
         nerr++; $display("FAIL multi_count: got %0d beats %0d pi beats timeout=%0d, expected 6 2", nout, npi, timed_out);
      end
      for (int k = 0; k < 6 && k < nout; k++) begin
         e = (k < 3) ? 32'(k * 32'h10000 + 32'h100) : 32'((k + 1) * 32'h2000);
         nvec++; if (ow[k] !== e || oi[k] !== 16'(k / 3) || oj[k] !== 16'(k % 3) || ol[k] !== (k == 5)) begin
            nerr++; $display("FAIL multi_beat%0d: got w=%h i=%0d j=%0d last=%b, expected %h %0d %0d %b",
                             k, ow[k], oi[k], oj[k], ol[k], e, k / 3, k % 3, k == 5);
         end
      end
      nvec++; if (rdy_cnt !== 1 || both_seen !== 1'b0) begin
         nerr++; $display("FAIL multi_ready: got %0d pulses both_ready=%b, expected 1 0", rdy_cnt, both_seen);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] e;
      load_multi_tables();
      run_job(2, 3, 4, 4, -1);
      nvec++; if (stall_bad !== 1'b0) begin
         nerr++; $display("FAIL stall_hold: got unstable/accepting=%b, expected 0", stall_bad);
      end
      nvec++; if (timed_out || nout !== 6) begin
         nerr++; $display("FAIL stall_count: got %0d beats timeout=%0d, expected 6", nout, timed_out);
      end
      for (int k = 0; k < 6 && k < nout; k++) begin
         e = (k < 3) ? 32'(k * 32'h10000 + 32'h100) : 32'((k + 1) * 32'h2000);
         nvec++; if (ow[k] !== e || oi[k] !== 16'(k / 3) || oj[k] !== 16'(k % 3)) begin
            nerr++; $display("FAIL stall_beat%0d: got w=%h i=%0d j=%0d, expected %h %0d %0d",
                             k, ow[k], oi[k], oj[k], e, k / 3, k % 3);
         end
      end
   endtask

   task automatic test_saturate();
      pi_tab[0] = pk(32'h10000, 32'h10000, 32'h10000);
      x_tab[0]  = pk(32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000);
      x_tab[1]  = pk(32'h80010000, 32'h80010000, 32'h80010000);
      x_tab[2]  = pk(32'h40000000, 32'h3FFFFFFF, 32'h0);
      run_job(1, 3, -100, 0, -1);
      nvec++; if (nout !== 3 || ow[0] !== 32'h7FFFFFFF) begin
         nerr++; $display("FAIL sat_hi: got %h (%0d beats), expected 7fffffff", ow[0], nout);
      end
      nvec++; if (ow[1] !== 32'h80000000) begin
         nerr++; $display("FAIL sat_lo: got %h, expected 80000000", ow[1]);
      end
      nvec++; if (ow[2] !== 32'h7FFFFFFF || ol[2] !== 1'b1) begin
         nerr++; $display("FAIL sat_edge: got %h last=%b, expected 7fffffff 1", ow[2], ol[2]);
      end
      // 0.5 * (-2^-16) floors to -2^-16; 0.5 * 3*2^-16 floors to 2^-16
      pi_tab[0] = pk(32'h8000, 32'h0, 32'h0);
      x_tab[0]  = pk(32'hFFFFFFFF, 32'h12345, 32'h0);
      x_tab[1]  = pk(32'h3, 32'h0, 32'h0);
      run_job(1, 2, -100, 0, -1);
      nvec++; if (nout !== 2 || ow[0] !== 32'hFFFFFFFF || ow[1] !== 32'h1) begin
         nerr++; $display("FAIL floor_shift: got %h %h (%0d beats), expected ffffffff 00000001", ow[0], ow[1], nout);
      end
   endtask

   task automatic test_zero_size();
      run_job(2, 0, -100, 0, -1);
      nvec++; if (nout !== 0 || pi_seen || x_seen) begin
         nerr++; $display("FAIL zero_n_quiet: got beats=%0d pi_rdy=%b x_rdy=%b, expected 0 0 0", nout, pi_seen, x_seen);
      end
      nvec++; if (rdy_cnt !== 1 || rdy_cyc < 1 || rdy_cyc > 2) begin
         nerr++; $display("FAIL zero_n_ready: got %0d pulses at cyc %0d, expected 1 at cyc 1..2", rdy_cnt, rdy_cyc);
      end
      run_job(0, 3, -100, 0, -1);
      nvec++; if (nout !== 0 || pi_seen || x_seen || rdy_cnt !== 1) begin
         nerr++; $display("FAIL zero_r: got beats=%0d pi=%b x=%b ready=%0d, expected 0 0 0 1", nout, pi_seen, x_seen, rdy_cnt);
      end
   endtask

   task automatic test_start_while_busy();
      pi_tab[0] = pk(32'h10000, 32'h0, 32'h0);
      x_tab[0]  = pk(32'h10000, 32'h0, 32'h0);
      x_tab[1]  = pk(32'h20000, 32'h0, 32'h0);
      run_job(1, 2, -100, 0, 2);
      nvec++; if (timed_out || nout !== 2 || rdy_cnt !== 1) begin
         nerr++; $display("FAIL busy_start: got %0d beats %0d pulses, expected 2 1", nout, rdy_cnt);
      end
      nvec++; if (ow[1] !== 32'h20000 || oj[1] !== 16'd1 || ol[1] !== 1'b1) begin
         nerr++; $display("FAIL busy_start_beat: got %h j=%0d last=%b, expected 00020000 1 1", ow[1], oj[1], ol[1]);
      end
   endtask

   task automatic test_reset_mid();
      pi_tab[0] = pk(32'h10000, 32'h0, 32'h0);
      x_tab[0]  = pk(32'h50000, 32'h0, 32'h0);
      x_tab[1]  = pk(32'h60000, 32'h0, 32'h0);
      @(negedge CLK);
      SIZE_R_IN = 16'd1; SIZE_N_IN = 16'd3; START = 1'b1;
      PI_VALID = 1'b1; PI_IN = pi_tab[0]; W_OUT_READY = 1'b0;
      @(negedge CLK); START = 1'b0;
      @(negedge CLK); PI_VALID = 1'b0; X_VALID = 1'b1; X_IN = x_tab[0];
      @(negedge CLK); X_VALID = 1'b0;
      #1;
      nvec++; if (W_OUT_VALID !== 1'b1 || W_OUT !== 32'h50000) begin
         nerr++; $display("FAIL rstmid_pre: got valid=%b w=%h, expected 1 00050000", W_OUT_VALID, W_OUT);
      end
      #2 RST = 1'b1;
      #1;
      nvec++; if ({READY, BUSY, PI_READY, X_READY, W_OUT_VALID, W_OUT_LAST} !== 6'b0) begin
         nerr++; $display("FAIL rstmid_ctrl: got %b, expected 000000", {READY, BUSY, PI_READY, X_READY, W_OUT_VALID, W_OUT_LAST});
      end
      nvec++; if ({W_OUT, W_OUT_I, W_OUT_J} !== 64'h0) begin
         nerr++; $display("FAIL rstmid_data: got %h, expected 0", {W_OUT, W_OUT_I, W_OUT_J});
      end
      @(negedge CLK); RST = 1'b0;
      repeat (3) @(negedge CLK);
      #1;
      nvec++; if (BUSY !== 1'b0 || W_OUT_VALID !== 1'b0) begin
         nerr++; $display("FAIL rstmid_idle: got busy=%b valid=%b, expected 0 0", BUSY, W_OUT_VALID);
      end
      run_job(1, 2, -100, 0, -1);
      nvec++; if (nout !== 2 || ow[0] !== 32'h50000 || oj[0] !== 16'd0 || ow[1] !== 32'h60000 || ol[1] !== 1'b1) begin
         nerr++; $display("FAIL rstmid_rerun: got %0d beats %h j=%0d %h last=%b, expected 2 00050000 0 00060000 1",
                          nout, ow[0], oj[0], ow[1], ol[1]);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_multi_head();
      test_backpressure();
      test_saturate();
      test_zero_size();
      test_start_while_busy();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
